// File: rtl/switch_arbiter.sv
// Crossbar arbiter for switch_4port: per-output round-robin grant into a
// registered holding stage with valid/ready backpressure and a drop counter.
module switch_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_PORTS-1:0]           in_valid,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] in_source,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] in_target,
    input  logic [NUM_PORTS*DATA_W-1:0]    in_data,
    output logic [NUM_PORTS-1:0]           in_ready,
    output logic [NUM_PORTS-1:0]           out_valid,
    output logic [NUM_PORTS*NUM_PORTS-1:0] out_source,
    output logic [NUM_PORTS*NUM_PORTS-1:0] out_target,
    output logic [NUM_PORTS*DATA_W-1:0]    out_data,
    input  logic [NUM_PORTS-1:0]           out_ready,
    output logic [CNT_W-1:0]               drop_cnt
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int NP = NUM_PORTS;

    logic [NP-1:0]        legal, illegal, can_load, gnt_any, in_gnt;
    logic [NP-1:0]        req [NP];
    logic [NP-1:0]        gnt [NP];
    logic [PW-1:0]        gnt_idx [NP];
    logic [NP-1:0]        vld_q, vld_d;
    logic [NP*NP-1:0]     src_q, src_d, tgt_q, tgt_d;
    logic [NP*DATA_W-1:0] dat_q, dat_d;
    logic [NP*PW-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W:0]       drop_sum;

    always_comb begin
        legal   = '0;
        illegal = '0;
        for (int i = 0; i < NP; i++) begin
            legal[i]   = $onehot(in_target[i*NP +: NP]);
            illegal[i] = in_valid[i] && !legal[i];
        end
    end

    always_comb begin
        for (int o = 0; o < NP; o++) begin
            req[o] = '0;
            for (int i = 0; i < NP; i++)
                req[o][i] = in_valid[i] && legal[i] && in_target[i*NP + o];
        end
    end

    assign can_load = ~vld_q | out_ready;

    // Search starts one past the last winner so the previous winner ranks last.
    always_comb begin
        int  idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        for (int o = 0; o < NP; o++) begin
            gnt[o]     = '0;
            gnt_idx[o] = '0;
            found      = 1'b0;
            for (int k = 1; k <= NP; k++) begin
                idx = (int'(ptr_q[o*PW +: PW]) + k) % NP;
                if (can_load[o] && !found && req[o][PW'(idx)]) begin
                    found               = 1'b1;
                    gnt[o][PW'(idx)]    = 1'b1;
                    gnt_idx[o]          = PW'(idx);
                end
            end
            gnt_any[o] = found;
        end
    end

    always_comb begin
        in_gnt = '0;
        for (int i = 0; i < NP; i++)
            for (int o = 0; o < NP; o++)
                in_gnt[i] = in_gnt[i] | gnt[o][i];
    end

    assign in_ready = {NP{rst_n}} & (illegal | in_gnt);

    always_comb begin
        vld_d    = vld_q;
        src_d    = src_q;
        tgt_d    = tgt_q;
        dat_d    = dat_q;
        ptr_d    = ptr_q;
        drop_sum = {1'b0, cnt_q};
        for (int o = 0; o < NP; o++) begin
            if (can_load[o]) begin
                vld_d[o] = gnt_any[o];
                if (gnt_any[o])
                    ptr_d[o*PW +: PW] = gnt_idx[o];
                for (int i = 0; i < NP; i++) begin
                    if (gnt[o][i]) begin
                        src_d[o*NP +: NP]         = in_source[i*NP +: NP];
                        tgt_d[o*NP +: NP]         = in_target[i*NP +: NP];
                        dat_d[o*DATA_W +: DATA_W] = in_data[i*DATA_W +: DATA_W];
                    end
                end
            end
        end
        for (int i = 0; i < NP; i++)
            drop_sum = drop_sum + (CNT_W+1)'(illegal[i]);
        // A carry into the top bit means the sum passed the maximum.
        cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            src_q <= '0;
            tgt_q <= '0;
            dat_q <= '0;
            ptr_q <= {NP{PW'(NP-1)}};
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            src_q <= src_d;
            tgt_q <= tgt_d;
            dat_q <= dat_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    assign out_valid  = vld_q;
    assign out_source = src_q;
    assign out_target = tgt_q;
    assign out_data   = dat_q;
    assign drop_cnt   = cnt_q;

endmodule

// File: tb/tb_switch_arbiter.sv
// Bench for switch_arbiter: directed scenarios plus random traffic, all
// checked against a packet-level reference model of the arbiter.
module tb_switch_arbiter;
    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int CW  = 8;
    localparam int MAX = 255;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    in_valid, in_ready, out_valid, out_ready;
    logic [N*N-1:0]  in_source, in_target, out_source, out_target;
    logic [N*DW-1:0] in_data, out_data;
    logic [CW-1:0]   drop_cnt;

    switch_arbiter #(.NUM_PORTS(N), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_source(in_source),
        .in_target(in_target), .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid), .out_source(out_source),
        .out_target(out_target), .out_data(out_data),
        .out_ready(out_ready), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic          m_vld [N];
    logic [N-1:0]  m_src [N];
    logic [N-1:0]  m_tgt [N];
    logic [DW-1:0] m_dat [N];
    int            m_last [N];
    int            m_drop;
    logic [N-1:0]  last_rdy;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(logic [N-1:0] t);
        return $countones(t) == 1;
    endfunction

    task automatic model_reset();
        for (int o = 0; o < N; o++) begin
            m_vld[o]  = 1'b0;
            m_src[o]  = '0;
            m_tgt[o]  = '0;
            m_dat[o]  = '0;
            m_last[o] = N - 1;
        end
        m_drop = 0;
    endtask

    task automatic set_in(int i, logic v, logic [N-1:0] t, logic [DW-1:0] d);
        in_valid[i]            = v;
        in_source[i*N +: N]    = N'(1) << i;
        in_target[i*N +: N]    = t;
        in_data[i*DW +: DW]    = d;
    endtask

    task automatic clear_in();
        in_valid  = '0;
        in_source = '0;
        in_target = '0;
        in_data   = '0;
    endtask

    // One cycle: check combinational and registered outputs, clock, update model.
    task automatic step();
        logic [N-1:0]    erdy, ev;
        logic [N*N-1:0]  es, et, as_, at_;
        logic [N*DW-1:0] ed, ad;
        int              g [N];
        int              nd;
        #1;
        erdy = '0;
        nd   = 0;
        for (int i = 0; i < N; i++)
            if (in_valid[i] && !is_legal(in_target[i*N +: N])) begin
                erdy[i] = 1'b1;
                nd++;
            end
        for (int o = 0; o < N; o++) begin
            g[o] = -1;
            if (!m_vld[o] || out_ready[o])
                for (int k = 1; k <= N; k++) begin
                    int i;
                    i = (m_last[o] + k) % N;
                    if (g[o] < 0 && in_valid[i] && is_legal(in_target[i*N +: N])
                        && in_target[i*N + o])
                        g[o] = i;
                end
            if (g[o] >= 0) erdy[g[o]] = 1'b1;
        end
        if (!rst_n) erdy = '0;
        ev = '0; es = '0; et = '0; ed = '0; as_ = '0; at_ = '0; ad = '0;
        for (int o = 0; o < N; o++) begin
            ev[o] = m_vld[o];
            if (m_vld[o]) begin
                es[o*N +: N]   = m_src[o];
                et[o*N +: N]   = m_tgt[o];
                ed[o*DW +: DW] = m_dat[o];
                as_[o*N +: N]  = out_source[o*N +: N];
                at_[o*N +: N]  = out_target[o*N +: N];
                ad[o*DW +: DW] = out_data[o*DW +: DW];
            end
        end
        chk("in_ready", in_ready, erdy);
        chk("out_valid", out_valid, ev);
        chk("out_source", as_, es);
        chk("out_target", at_, et);
        chk("out_data", ad, ed);
        chk("drop_cnt", drop_cnt, m_drop);
        last_rdy = in_ready;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int o = 0; o < N; o++) begin
                if (g[o] >= 0) begin
                    m_vld[o]  = 1'b1;
                    m_src[o]  = in_source[g[o]*N +: N];
                    m_tgt[o]  = in_target[g[o]*N +: N];
                    m_dat[o]  = in_data[g[o]*DW +: DW];
                    m_last[o] = g[o];
                end else if (out_ready[o]) begin
                    m_vld[o] = 1'b0;
                end
            end
            m_drop = (m_drop + nd > MAX) ? MAX : m_drop + nd;
        end
        #1;
    endtask

    initial begin
        logic [N-1:0] seq [6];
        logic [31:0]  r;
        logic [N-1:0] t;
        seq = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
        rst_n     = 1'b0;
        out_ready = '0;
        clear_in();
        model_reset();
        @(posedge clk);
        #1;
        step();
        rst_n = 1'b1;

        // Single packet
        out_ready = 4'hF;
        set_in(0, 1'b1, 4'b0100, 8'hA5);
        step();
        chk("sp_ready", last_rdy, 4'b0001);
        clear_in();
        chk("sp_valid", out_valid, 4'b0100);
        chk("sp_data", out_data[2*DW +: DW], 8'hA5);
        chk("sp_src", out_source[2*N +: N], 4'b0001);
        step();
        chk("sp_clear", out_valid, 4'b0000);

        // Contention on output 1
        set_in(0, 1'b1, 4'b0010, 8'h10);
        set_in(1, 1'b1, 4'b0010, 8'h11);
        set_in(3, 1'b1, 4'b0010, 8'h13);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("cont_grant", last_rdy, seq[k]);
            chk("cont_nobubble", out_valid[1], 1'b1);
        end
        clear_in();
        step();

        // Backpressure on output 3
        out_ready = 4'b0111;
        set_in(2, 1'b1, 4'b1000, 8'h20);
        step();
        chk("bp_first", last_rdy, 4'b0100);
        set_in(2, 1'b1, 4'b1000, 8'h21);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_stall", last_rdy, 4'b0000);
            chk("bp_hold", out_data[3*DW +: DW], 8'h20);
        end
        out_ready = 4'hF;
        step();
        chk("bp_b2b_ready", last_rdy, 4'b0100);
        chk("bp_b2b_data", out_data[3*DW +: DW], 8'h21);
        chk("bp_b2b_valid", out_valid[3], 1'b1);
        clear_in();
        step();

        // Parallel outputs
        set_in(0, 1'b1, 4'b0001, 8'h30);
        set_in(1, 1'b1, 4'b0010, 8'h31);
        set_in(2, 1'b1, 4'b0100, 8'h32);
        set_in(3, 1'b1, 4'b1000, 8'h33);
        step();
        chk("par_ready", last_rdy, 4'b1111);
        chk("par_valid", out_valid, 4'b1111);
        chk("par_data", out_data, 32'h33323130);
        clear_in();
        step();

        // Illegal targets and saturation
        set_in(1, 1'b1, 4'b0000, 8'h40);
        set_in(2, 1'b1, 4'b0110, 8'h41);
        step();
        chk("ill_ready", last_rdy, 4'b0110);
        chk("ill_valid", out_valid, 4'b0000);
        chk("ill_cnt", drop_cnt, 8'd2);
        clear_in();
        for (int i = 0; i < N; i++) set_in(i, 1'b1, 4'b0000, 8'h00);
        for (int k = 0; k < 75; k++) step();
        chk("sat_cnt", drop_cnt, 8'd255);
        step();
        chk("sat_hold", drop_cnt, 8'd255);
        clear_in();
        step();

        // Reset mid-flight
        out_ready = 4'h0;
        set_in(0, 1'b1, 4'b0001, 8'h50);
        set_in(1, 1'b1, 4'b0010, 8'h51);
        set_in(2, 1'b1, 4'b0100, 8'h52);
        set_in(3, 1'b1, 4'b1000, 8'h53);
        step();
        clear_in();
        chk("rst_pre_valid", out_valid, 4'b1111);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_valid", out_valid, 4'b0000);
        chk("rst_cnt", drop_cnt, 8'd0);
        out_ready = 4'hF;
        set_in(2, 1'b1, 4'b0001, 8'h62);
        set_in(1, 1'b1, 4'b0001, 8'h61);
        set_in(0, 1'b1, 4'b0001, 8'h60);
        step();
        chk("rst_first_grant", last_rdy, 4'b0001);
        clear_in();
        step();

        // Random traffic with held packets under backpressure
        for (int c = 0; c < 600; c++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            r         = $urandom;
            out_ready = r[N-1:0];
            for (int i = 0; i < N; i++) begin
                if (!in_valid[i] || last_rdy[i]) begin
                    r = $urandom;
                    if ($urandom_range(0, 9) < 8) t = N'(1) << $urandom_range(0, N-1);
                    else t = r[11:8];
                    set_in(i, ($urandom_range(0, 9) < 7), t, r[7:0]);
                end
            end
            step();
        end
        rst_n = 1'b1;
        clear_in();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/switch_arbiter.md
Name: switch_arbiter

Overview:
Central arbitration and crossbar stage of switch_4port. It sits directly downstream of the four switch_port ingress instances and consumes their (valid, source, target, data) packets. For each output port it round-robins among the inputs targeting that port and registers the winning packet into a per-output holding register with valid/ready backpressure. Single-beat packets only; target is one-hot.

Parameters:
NUM_PORTS, 4, number of switch ports; input and output count; width of source/target one-hot fields
DATA_W, 8, packet data width in bits
CNT_W, 8, width of the saturating drop counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  NUM_PORTS  packet valid per input i
in_source  in  NUM_PORTS*NUM_PORTS  one-hot source field per input, input i at slice [i*NUM_PORTS +: NUM_PORTS]
in_target  in  NUM_PORTS*NUM_PORTS  one-hot target field per input, same slicing
in_data  in  NUM_PORTS*DATA_W  data per input, input i at slice [i*DATA_W +: DATA_W]
in_ready  out  NUM_PORTS  input i packet accepted this cycle (combinational)
out_valid  out  NUM_PORTS  output o holding register valid
out_source  out  NUM_PORTS*NUM_PORTS  registered source per output
out_target  out  NUM_PORTS*NUM_PORTS  registered target per output
out_data  out  NUM_PORTS*DATA_W  registered data per output
out_ready  in  NUM_PORTS  output o sink accepts packet this cycle
drop_cnt  out  CNT_W  count of dropped illegal packets, saturating

Behaviour:
- Clock/reset: single clock clk; rst_n synchronous, active-low, sampled on rising edge only.
- Reset values: out_valid=0, out_source/out_target/out_data=0, drop_cnt=0, rr_ptr[o]=NUM_PORTS-1 for every output (input 0 has first priority).
- Legal packet: in_target[i] has exactly one bit set. Input i requests output o when in_valid[i] && legal && in_target[i][o].
- Illegal packet: in_valid[i] with zero or multiple target bits set. Consumed immediately (in_ready[i]=1 same cycle), never forwarded. drop_cnt += number of illegal inputs that cycle, saturating at 2^CNT_W-1.
- Output o can load when !out_valid[o] || out_ready[o]. A simultaneous drain and load is a back-to-back transfer with no bubble.
- Grant: when output o can load and has at least one requester, grant the first requester found searching (rr_ptr[o]+1) mod NUM_PORTS upward with wrap. in_ready[i]=1 for the granted input only. Non-granted requesters get in_ready=0 and must hold their packet stable.
- On grant at edge N: the holding register loads the granted input's source/target/data, out_valid[o]=1 from N+1, rr_ptr[o]=granted index. Latency is 1 cycle from acceptance.
- No grant: rr_ptr unchanged. out_valid[o] clears when drained with no new load.
- While out_valid[o] && !out_ready[o]: out_* hold stable; no grant issued for o.
- Conflict freedom: each legal input targets exactly one output, so an input is granted at most once per cycle. Different outputs arbitrate independently and concurrently.
- Fairness: a continuously requesting input is granted within NUM_PORTS-1 grants of its output.
- Loopback (source bit == target bit) is legal and forwarded normally.
- Reset mid-operation: buffered packets are discarded, all registers return to reset values next edge, and in_ready is 0 during the reset cycle.
- All of in_ready is purely combinational from in_*, out_valid, out_ready, and rr_ptr. No combinational path exists from in_* to out_*.

Test Plan:
- Single packet: in0 valid, target=0100, data=0xA5, out_ready=1111 -> in_ready[0]=1 at cycle 0; out_valid=0100, out_data[2]=0xA5, out_source[2]=0001 at cycle 1, then out_valid clears.
- Contention: in0, in1, in3 all target 0010 continuously, out_ready[1]=1 -> grants in order 0,1,3,0,1,3; one packet per cycle on output 1, no bubbles.
- Backpressure: out_ready[3]=0 for 5 cycles with in2 targeting 1000 -> first packet held stable in output 3, in_ready[2]=0 for those cycles; out_ready=1 -> drain and next packet back-to-back.
- Parallel outputs: in0->0001, in1->0010, in2->0100, in3->1000 in the same cycle -> all in_ready=1; all four outputs valid the next cycle with matching data.
- Illegal targets: in1 target=0000 and in2 target=0110 in the same cycle -> both in_ready=1, no out_valid, drop_cnt +2. 300 illegal packets with CNT_W=8 -> drop_cnt saturates at 255.
- Reset mid-flight: out_valid=1111 with out_ready=0, then assert rst_n=0 for one cycle -> out_valid=0, drop_cnt=0. Next contention on output 0 grants input 0 first.
